// File: rtl/if_stage_pkg.sv
// Shared fetch-stage definitions: bubble encoding, SYSTEM opcode and fetch FSM states.
package if_stage_pkg;

    localparam int unsigned INSTR_W = 32;
    localparam int unsigned OPC_W   = 7;

    localparam logic [INSTR_W-1:0] BUBBLE_INSTR  = 32'h0000_0013;
    localparam logic [OPC_W-1:0]   OPCODE_SYSTEM = 7'b1110011;

    typedef enum logic [1:0] {
        ST_BOOT = 2'd0,
        ST_RUN  = 2'd1,
        ST_HALT = 2'd2
    } fetch_state_e;

endpackage

// File: rtl/if_stage_if_id_reg.sv
// IF/ID pipeline register: kill loads a bubble, stall holds, load captures the fetched word.
module if_id_reg
    import if_stage_pkg::*;
#(
    parameter int unsigned          PC_W      = 20,
    parameter logic [INSTR_W-1:0]   NOP_INSTR = BUBBLE_INSTR
) (
    input  logic                clk,
    input  logic                reset_n,
    input  logic                kill_i,
    input  logic                stall_i,
    input  logic                load_i,
    input  logic [INSTR_W-1:0]  instr_i,
    input  logic [PC_W-1:0]     pc_i,
    output logic [PC_W-1:0]     id_pc_o,
    output logic [PC_W-1:0]     id_pcplus4_o,
    output logic [INSTR_W-1:0]  id_instr_o,
    output logic                id_valid_o
);

    logic [PC_W-1:0]    pc_q, pc_d;
    logic [PC_W-1:0]    pcplus4_q, pcplus4_d;
    logic [INSTR_W-1:0] instr_q, instr_d;
    logic               valid_q, valid_d;

    // Priority: kill > stall > load; anything else (boot, halted) is a bubble.
    always_comb begin
        pc_d      = pc_q;
        pcplus4_d = pcplus4_q;
        instr_d   = instr_q;
        valid_d   = valid_q;
        if (kill_i || (!stall_i && !load_i)) begin
            pc_d      = '0;
            pcplus4_d = '0;
            instr_d   = NOP_INSTR;
            valid_d   = 1'b0;
        end else if (!stall_i) begin
            pc_d      = pc_i;
            pcplus4_d = pc_i + PC_W'(4);
            instr_d   = instr_i;
            valid_d   = 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            pc_q      <= '0;
            pcplus4_q <= '0;
            instr_q   <= NOP_INSTR;
            valid_q   <= 1'b0;
        end else begin
            pc_q      <= pc_d;
            pcplus4_q <= pcplus4_d;
            instr_q   <= instr_d;
            valid_q   <= valid_d;
        end
    end

    assign id_pc_o      = pc_q;
    assign id_pcplus4_o = pcplus4_q;
    assign id_instr_o   = instr_q;
    assign id_valid_o   = valid_q;

endmodule

// File: rtl/if_stage.sv
// Instruction-fetch stage: PC, next-PC mux, boot/run/halt fetch FSM and IF/ID register.
module if_stage
    import if_stage_pkg::*;
#(
    parameter int unsigned          PC_W      = 20,
    parameter logic [PC_W-1:0]      RESET_PC  = '0,
    parameter logic [INSTR_W-1:0]   NOP_INSTR = BUBBLE_INSTR
) (
    input  logic                clk,
    input  logic                reset_n,
    input  logic                IF_IDStall,
    input  logic                IF_IDFlush,
    input  logic                EX_PCSrc,
    input  logic [PC_W-1:0]     EX_TargetAddr,
    output logic [PC_W-1:0]     IMem_addr,
    input  logic [INSTR_W-1:0]  IMem_rdata,
    output logic [PC_W-1:0]     ID_PC,
    output logic [PC_W-1:0]     ID_PCplus4,
    output logic [INSTR_W-1:0]  ID_instr,
    output logic                ID_valid,
    output logic                IF_halted,
    output logic                IF_misaligned
);

    fetch_state_e    state_q, state_d;
    logic [PC_W-1:0] pc_q, pc_d;
    logic            halted_q, halted_d;
    logic            misaligned_q, misaligned_d;
    logic [PC_W-1:0] target;
    logic            kill;
    logic            advance;

    always_comb begin
        state_d      = state_q;
        pc_d         = pc_q;
        target       = {EX_TargetAddr[PC_W-1:2], 2'b00};
        kill         = EX_PCSrc | IF_IDFlush;
        advance      = (state_q == ST_RUN) && !kill && !IF_IDStall;
        misaligned_d = misaligned_q | (EX_PCSrc & (EX_TargetAddr[1:0] != 2'b00));

        case (state_q)
            ST_BOOT: begin
                pc_d    = RESET_PC;
                state_d = ST_RUN;
            end
            ST_RUN: begin
                pc_d = IF_IDStall ? pc_q : pc_q + PC_W'(4);
                // SYSTEM still enters ID; fetch freezes behind it.
                if (advance && (IMem_rdata[OPC_W-1:0] == OPCODE_SYSTEM)) begin
                    state_d = ST_HALT;
                end
            end
            ST_HALT: begin
                pc_d = pc_q;
            end
            default: begin
                pc_d    = RESET_PC;
                state_d = ST_BOOT;
            end
        endcase

        // A redirect overrides every state, including halt entry this cycle.
        if (EX_PCSrc) begin
            pc_d    = target;
            state_d = ST_RUN;
        end

        halted_d = (state_d == ST_HALT);
    end

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            state_q      <= ST_BOOT;
            pc_q         <= RESET_PC;
            halted_q     <= 1'b0;
            misaligned_q <= 1'b0;
        end else begin
            state_q      <= state_d;
            pc_q         <= pc_d;
            halted_q     <= halted_d;
            misaligned_q <= misaligned_d;
        end
    end

    assign IMem_addr     = reset_n ? pc_d : RESET_PC;
    assign IF_halted     = halted_q;
    assign IF_misaligned = misaligned_q;

    if_id_reg #(
        .PC_W      (PC_W),
        .NOP_INSTR (NOP_INSTR)
    ) u_if_id_reg (
        .clk          (clk),
        .reset_n      (reset_n),
        .kill_i       (kill),
        .stall_i      (IF_IDStall),
        .load_i       (state_q == ST_RUN),
        .instr_i      (IMem_rdata),
        .pc_i         (pc_q),
        .id_pc_o      (ID_PC),
        .id_pcplus4_o (ID_PCplus4),
        .id_instr_o   (ID_instr),
        .id_valid_o   (ID_valid)
    );

endmodule
